fifo_uart_tx_drain: RTL and testbench



---
 rtl/fifo_uart_pkg.sv | 26 ++
 rtl/uart_parity_calc.sv | 26 ++
 rtl/fifo_uart_tx_drain.sv | 140 ++++++++++++++
 tb/tb_fifo_uart_tx_drain.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_uart_pkg.sv
// Shared encodings for the FIFO-drain UART transmitter:
// FSM state codes, parity-type codes and line levels.
package fifo_uart_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        START  = ST_START,
        DATA   = ST_DATA,
        PARITY = ST_PARITY,
        STOP   = ST_STOP
    } tx_state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_parity_calc.sv
// Combinational UART parity bit for a data word.
// Ports: data (word), par_typ (0 even / 1 odd), parity (bit to send).
module uart_parity_calc
    import fifo_uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  par_typ,
    output logic                  parity
);

    logic ones_odd;

    assign ones_odd = ^data;

    always_comb begin
        parity = ones_odd;
        unique case (par_typ)
            PAR_EVEN: parity = ones_odd;
            PAR_ODD:  parity = ~ones_odd;
            default:  parity = ones_odd;
        endcase
    end

endmodule

// File: rtl/fifo_uart_tx_drain.sv
// Drains an async FIFO read side and sends each word as a UART frame
// (start, LSB-first data, optional parity, stop), one bit per CLK.
// Ports: CLK/RST (sync, active-low), FIFO_EMPTY, FIFO_RD_DATA,
//   PAR_EN, PAR_TYP in; FIFO_RD_INC, TX_OUT, BUSY out (registered).
// Optional macro TX_DRAIN_FRAME_CNT_EN adds FRAME_CNT[15:0].
module fifo_uart_tx_drain
    import fifo_uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  FIFO_EMPTY,
    input  logic [DATA_WIDTH-1:0] FIFO_RD_DATA,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  FIFO_RD_INC,
    output logic                  TX_OUT,
    output logic                  BUSY
`ifdef TX_DRAIN_FRAME_CNT_EN
    ,
    output logic [15:0]           FRAME_CNT
`endif
);

    localparam int CNT_W =
        (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT =
        CNT_W'(DATA_WIDTH - 1);

    tx_state_t             state_q;
    tx_state_t             state_d;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] word_q;
    logic [CNT_W-1:0]      bit_cnt_q;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic                  pop;
    logic                  par_bit;
    logic                  tx_d;
    logic                  busy_d;

    // Parity comes from the frame copy, not the shifting register.
    uart_parity_calc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity (
        .data    (word_q),
        .par_typ (par_typ_q),
        .parity  (par_bit)
    );

    always_comb begin
        pop     = 1'b0;
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (!FIFO_EMPTY) begin
                    pop     = 1'b1;
                    state_d = START;
                end
            end
            START: state_d = DATA;
            DATA: begin
                if (bit_cnt_q == LAST_BIT) begin
                    state_d = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: state_d = STOP;
            STOP: begin
                // Chain the next frame with no idle gap.
                if (!FIFO_EMPTY) begin
                    pop     = 1'b1;
                    state_d = START;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered, so they are decoded from the
    // state being entered rather than the current one.
    always_comb begin
        tx_d   = IDLE_LEVEL;
        busy_d = 1'b1;
        unique case (state_d)
            IDLE:    busy_d = 1'b0;
            START:   tx_d   = START_BIT;
            DATA:    tx_d   = shift_q[0];
            PARITY:  tx_d   = par_bit;
            STOP:    tx_d   = STOP_BIT;
            default: busy_d = 1'b0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            word_q      <= '0;
            bit_cnt_q   <= '0;
            par_en_q    <= 1'b0;
            par_typ_q   <= 1'b0;
            TX_OUT      <= IDLE_LEVEL;
            BUSY        <= 1'b0;
            FIFO_RD_INC <= 1'b0;
        end else begin
            state_q     <= state_d;
            TX_OUT      <= tx_d;
            BUSY        <= busy_d;
            FIFO_RD_INC <= pop;
            if (pop) begin
                shift_q   <= FIFO_RD_DATA;
                word_q    <= FIFO_RD_DATA;
                par_en_q  <= PAR_EN;
                par_typ_q <= PAR_TYP;
            end else if (state_d == DATA) begin
                shift_q <= shift_q >> 1;
            end
            if (state_d == DATA && state_q == DATA) begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
            end else begin
                bit_cnt_q <= '0;
            end
        end
    end

`ifdef TX_DRAIN_FRAME_CNT_EN
    // Counts frames whose STOP cycle ran to completion.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            FRAME_CNT <= '0;
        end else if (state_q == STOP) begin
            FRAME_CNT <= FRAME_CNT + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_uart_tx_drain.sv
// Self-checking bench for fifo_uart_tx_drain: FIFO queue model plus
// a frame-level line model compared cycle by cycle.
module tb_fifo_uart_tx_drain;

    logic       CLK;
    logic       RST;
    logic       FIFO_EMPTY;
    logic [7:0] FIFO_RD_DATA;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       FIFO_RD_INC;
    logic       TX_OUT;
    logic       BUSY;
`ifdef TX_DRAIN_FRAME_CNT_EN
    logic [15:0] FRAME_CNT;
`endif

    int n_checks;
    int n_errors;

    logic [7:0] fifo_q[$];
    bit         exp_tx[$];
    bit         exp_busy[$];
    bit         exp_inc[$];
    logic       obs_tx[$];
    logic       obs_busy[$];
    logic       obs_inc[$];
    logic       s_tx;
    logic       s_busy;
    logic       s_inc;

    fifo_uart_tx_drain #(
        .DATA_WIDTH (8)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .FIFO_EMPTY   (FIFO_EMPTY),
        .FIFO_RD_DATA (FIFO_RD_DATA),
        .PAR_EN       (PAR_EN),
        .PAR_TYP      (PAR_TYP),
        .FIFO_RD_INC  (FIFO_RD_INC),
        .TX_OUT       (TX_OUT),
        .BUSY         (BUSY)
`ifdef TX_DRAIN_FRAME_CNT_EN
        ,
        .FRAME_CNT    (FRAME_CNT)
`endif
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    // One cycle: sample at negedge, then service the FIFO model.
    task automatic tick();
        @(negedge CLK);
        s_tx   = TX_OUT;
        s_busy = BUSY;
        s_inc  = FIFO_RD_INC;
        if (s_inc === 1'b1) begin
            n_checks++;
            if (fifo_q.size() == 0) begin
                n_errors++;
                $display("FAIL underflow: pop with FIFO empty");
            end else begin
                void'(fifo_q.pop_front());
            end
        end
        FIFO_EMPTY   = (fifo_q.size() == 0);
        FIFO_RD_DATA = (fifo_q.size() != 0) ? fifo_q[0]
                                            : 8'($urandom);
    endtask

    task automatic push_word(input logic [7:0] w);
        fifo_q.push_back(w);
        FIFO_EMPTY   = 1'b0;
        FIFO_RD_DATA = fifo_q[0];
    endtask

    task automatic clear_model();
        exp_tx.delete();
        exp_busy.delete();
        exp_inc.delete();
        obs_tx.delete();
        obs_busy.delete();
        obs_inc.delete();
    endtask

    // Frame as the line should show it: start, LSB first, parity, stop.
    function automatic void model_frame(input logic [7:0] w,
                                        input bit pe,
                                        input bit pt);
        exp_tx.push_back(1'b0);
        exp_busy.push_back(1'b1);
        exp_inc.push_back(1'b1);
        for (int i = 0; i < 8; i++) begin
            exp_tx.push_back(w[i]);
            exp_busy.push_back(1'b1);
            exp_inc.push_back(1'b0);
        end
        if (pe) begin
            exp_tx.push_back(bit'(($countones(w) % 2) != 0) ^ pt);
            exp_busy.push_back(1'b1);
            exp_inc.push_back(1'b0);
        end
        exp_tx.push_back(1'b1);
        exp_busy.push_back(1'b1);
        exp_inc.push_back(1'b0);
    endfunction

    function automatic void model_idle(input int n);
        for (int i = 0; i < n; i++) begin
            exp_tx.push_back(1'b1);
            exp_busy.push_back(1'b0);
            exp_inc.push_back(1'b0);
        end
    endfunction

    task automatic record(input int n, input bit scramble);
        for (int i = 0; i < n; i++) begin
            tick();
            obs_tx.push_back(s_tx);
            obs_busy.push_back(s_busy);
            obs_inc.push_back(s_inc);
            if (scramble) begin
                PAR_EN  = 1'($urandom);
                PAR_TYP = 1'($urandom);
            end
        end
    endtask

    task automatic test_reset();
        RST = 1'b0;
        tick();
        tick();
        n_checks++;
        if (s_tx !== 1'b1 || s_busy !== 1'b0 || s_inc !== 1'b0) begin
            n_errors++;
            $display("FAIL reset: tx/busy/inc=%b%b%b need 100",
                     s_tx, s_busy, s_inc);
        end
        RST = 1'b1;
    endtask

    task automatic test_idle();
        for (int i = 0; i < 50; i++) begin
            tick();
            n_checks++;
            if (s_tx !== 1'b1 || s_busy !== 1'b0 ||
                s_inc !== 1'b0) begin
                n_errors++;
                $display("FAIL idle cyc %0d: tx/busy/inc=%b%b%b need 100",
                         i, s_tx, s_busy, s_inc);
            end
        end
    endtask

    task automatic test_single();
        bit pe_v[3] = '{1'b0, 1'b1, 1'b1};
        bit pt_v[3] = '{1'b0, 1'b0, 1'b1};
        for (int c = 0; c < 3; c++) begin
            clear_model();
            PAR_EN  = pe_v[c];
            PAR_TYP = pt_v[c];
            push_word(8'hA5);
            model_frame(8'hA5, pe_v[c], pt_v[c]);
            model_idle(3);
            record(exp_tx.size(), 1'b1);
            for (int i = 0; i < exp_tx.size(); i++) begin
                n_checks++;
                if (obs_tx[i] !== exp_tx[i] ||
                    obs_busy[i] !== exp_busy[i] ||
                    obs_inc[i] !== exp_inc[i]) begin
                    n_errors++;
                    $display("FAIL single_a5 cfg%0d cyc %0d: %b%b%b need %b%b%b",
                             c, i, obs_tx[i], obs_busy[i], obs_inc[i],
                             exp_tx[i], exp_busy[i], exp_inc[i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int pulses;
        clear_model();
        PAR_EN  = 1'b0;
        PAR_TYP = 1'b0;
        for (int w = 1; w <= 3; w++) begin
            push_word(8'(w));
            model_frame(8'(w), 1'b0, 1'b0);
        end
        model_idle(3);
        record(exp_tx.size(), 1'b0);
        pulses = 0;
        for (int i = 0; i < exp_tx.size(); i++) begin
            if (obs_inc[i] === 1'b1) pulses++;
            n_checks++;
            if (obs_tx[i] !== exp_tx[i] ||
                obs_busy[i] !== exp_busy[i] ||
                obs_inc[i] !== exp_inc[i]) begin
                n_errors++;
                $display("FAIL b2b cyc %0d: %b%b%b need %b%b%b",
                         i, obs_tx[i], obs_busy[i], obs_inc[i],
                         exp_tx[i], exp_busy[i], exp_inc[i]);
            end
        end
        n_checks++;
        if (pulses != 3) begin
            n_errors++;
            $display("FAIL b2b_pulses: got %0d need 3", pulses);
        end
    endtask

    task automatic test_reset_mid_frame();
        clear_model();
        PAR_EN  = 1'b0;
        PAR_TYP = 1'b0;
        push_word(8'hFF);
        push_word(8'h3C);
        model_frame(8'hFF, 1'b0, 1'b0);
        record(6, 1'b0);
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (obs_tx[i] !== exp_tx[i] ||
                obs_busy[i] !== exp_busy[i]) begin
                n_errors++;
                $display("FAIL abort_pre cyc %0d: %b%b need %b%b",
                         i, obs_tx[i], obs_busy[i],
                         exp_tx[i], exp_busy[i]);
            end
        end
        RST = 1'b0;
        tick();
        n_checks++;
        if (s_tx !== 1'b1 || s_busy !== 1'b0 || s_inc !== 1'b0 ||
            fifo_q.size() != 1) begin
            n_errors++;
            $display("FAIL abort: tx/busy/inc=%b%b%b left=%0d need 100/1",
                     s_tx, s_busy, s_inc, fifo_q.size());
        end
        RST = 1'b1;
        clear_model();
        model_frame(8'h3C, 1'b0, 1'b0);
        model_idle(3);
        record(exp_tx.size(), 1'b0);
        for (int i = 0; i < exp_tx.size(); i++) begin
            n_checks++;
            if (obs_tx[i] !== exp_tx[i] ||
                obs_busy[i] !== exp_busy[i] ||
                obs_inc[i] !== exp_inc[i]) begin
                n_errors++;
                $display("FAIL abort_post cyc %0d: %b%b%b need %b%b%b",
                         i, obs_tx[i], obs_busy[i], obs_inc[i],
                         exp_tx[i], exp_busy[i], exp_inc[i]);
            end
        end
    endtask

    task automatic test_random();
        int         nw;
        bit         pe;
        bit         pt;
        logic [7:0] w;
        for (int it = 0; it < 16; it++) begin
            clear_model();
            repeat ($urandom_range(0, 2)) tick();
            nw      = $urandom_range(1, 3);
            pe      = 1'($urandom);
            pt      = 1'($urandom);
            PAR_EN  = pe;
            PAR_TYP = pt;
            for (int k = 0; k < nw; k++) begin
                w = 8'($urandom);
                push_word(w);
                model_frame(w, pe, pt);
            end
            model_idle(2);
            record(exp_tx.size(), nw == 1);
            for (int i = 0; i < exp_tx.size(); i++) begin
                n_checks++;
                if (obs_tx[i] !== exp_tx[i] ||
                    obs_busy[i] !== exp_busy[i] ||
                    obs_inc[i] !== exp_inc[i]) begin
                    n_errors++;
                    $display("FAIL rand it%0d cyc %0d: %b%b%b need %b%b%b",
                             it, i, obs_tx[i], obs_busy[i], obs_inc[i],
                             exp_tx[i], exp_busy[i], exp_inc[i]);
                end
            end
        end
    endtask

`ifdef TX_DRAIN_FRAME_CNT_EN
    task automatic test_frame_cnt();
        int frames;
        RST = 1'b0;
        tick();
        n_checks++;
        if (FRAME_CNT !== 16'd0) begin
            n_errors++;
            $display("FAIL cnt_reset: got %0d need 0", FRAME_CNT);
        end
        RST     = 1'b1;
        PAR_EN  = 1'b0;
        frames  = 0;
        for (int k = 0; k < 3; k++) begin
            push_word(8'($urandom));
            frames++;
        end
        repeat (3 * 10 + 2) tick();
        push_word(8'h55);
        repeat (5) tick();
        n_checks++;
        if (FRAME_CNT !== 16'(frames)) begin
            n_errors++;
            $display("FAIL cnt_pre: got %0d need %0d", FRAME_CNT, frames);
        end
        RST = 1'b0;
        tick();
        n_checks++;
        if (FRAME_CNT !== 16'd0) begin
            n_errors++;
            $display("FAIL cnt_post: got %0d need 0", FRAME_CNT);
        end
        RST = 1'b1;
        repeat (3) tick();
    endtask
`endif

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        RST          = 1'b0;
        FIFO_EMPTY   = 1'b1;
        FIFO_RD_DATA = 8'h00;
        PAR_EN       = 1'b0;
        PAR_TYP      = 1'b0;
        test_reset();
        test_idle();
        test_single();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
`ifdef TX_DRAIN_FRAME_CNT_EN
        test_frame_cnt();
`endif
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
